// File: rtl/vga_timing_generator.sv
// VGA raster timing: free-running h/v counters with frame-boundary shadowed configuration,
// combinational fetch outputs and a registered (one cycle later) display/sync stage.
module vga_timing_generator #(
  parameter int unsigned H_VISIBLE   = 100,
  parameter int unsigned H_FRONT     = 5,
  parameter int unsigned H_SYNC      = 16,
  parameter int unsigned H_BACK      = 11,
  parameter int unsigned V_VISIBLE   = 600,
  parameter int unsigned V_FRONT     = 1,
  parameter int unsigned V_SYNC      = 4,
  parameter int unsigned V_BACK      = 23,
  parameter bit          SYNC_ACTIVE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [10:0] cfg_h_visible,
  input  logic [10:0] cfg_h_front,
  input  logic [10:0] cfg_h_sync,
  input  logic [10:0] cfg_h_back,
  input  logic [9:0]  cfg_v_visible,
  input  logic [9:0]  cfg_v_front,
  input  logic [9:0]  cfg_v_sync,
  input  logic [9:0]  cfg_v_back,
  output logic        fetch_valid,
  output logic [10:0] fetch_x,
  output logic [9:0]  fetch_y,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic [10:0] pixel_x,
  output logic [9:0]  pixel_y,
  output logic        line_start,
  output logic        frame_start
);

  // Shadowed configuration
  logic [10:0] h_vis_q, h_vis_d, h_front_q, h_front_d, h_sync_q, h_sync_d, h_back_q, h_back_d;
  logic [9:0]  v_vis_q, v_vis_d, v_front_q, v_front_d, v_sync_q, v_sync_d, v_back_q, v_back_d;

  // Raster counters, wide enough for the full 12-bit / 11-bit totals
  logic [11:0] h_count_q, h_count_d;
  logic [10:0] v_count_q, v_count_d;

  // Registered output stage
  logic        hsync_q, hsync_d, vsync_q, vsync_d;
  logic        active_q, active_d, line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic [10:0] pixel_x_q, pixel_x_d;
  logic [9:0]  pixel_y_q, pixel_y_d;

  logic [11:0] h_total, h_sync_start, h_sync_end;
  logic [10:0] v_total, v_sync_start, v_sync_end;
  logic        h_wrap, v_wrap, frame_wrap, load_cfg;
  logic        h_in_vis, v_in_vis, h_in_sync, v_in_sync;

  always_comb begin
    h_total      = {1'b0, h_vis_q} + {1'b0, h_front_q} + {1'b0, h_sync_q} + {1'b0, h_back_q};
    v_total      = {1'b0, v_vis_q} + {1'b0, v_front_q} + {1'b0, v_sync_q} + {1'b0, v_back_q};
    h_sync_start = {1'b0, h_vis_q} + {1'b0, h_front_q};
    h_sync_end   = h_sync_start + {1'b0, h_sync_q};
    v_sync_start = {1'b0, v_vis_q} + {1'b0, v_front_q};
    v_sync_end   = v_sync_start + {1'b0, v_sync_q};

    // A zero total wraps every cycle rather than running off to the counter limit
    h_wrap     = ({1'b0, h_count_q} + 13'd1) >= {1'b0, h_total};
    v_wrap     = ({1'b0, v_count_q} + 12'd1) >= {1'b0, v_total};
    frame_wrap = enable && h_wrap && v_wrap;
    load_cfg   = !enable || frame_wrap;

    h_in_vis  = h_count_q < {1'b0, h_vis_q};
    v_in_vis  = v_count_q < {1'b0, v_vis_q};
    h_in_sync = (h_count_q >= h_sync_start) && (h_count_q < h_sync_end);
    v_in_sync = (v_count_q >= v_sync_start) && (v_count_q < v_sync_end);
  end

  always_comb begin
    h_vis_d   = h_vis_q;
    h_front_d = h_front_q;
    h_sync_d  = h_sync_q;
    h_back_d  = h_back_q;
    v_vis_d   = v_vis_q;
    v_front_d = v_front_q;
    v_sync_d  = v_sync_q;
    v_back_d  = v_back_q;
    if (load_cfg) begin
      h_vis_d   = cfg_h_visible;
      h_front_d = cfg_h_front;
      h_sync_d  = cfg_h_sync;
      h_back_d  = cfg_h_back;
      v_vis_d   = cfg_v_visible;
      v_front_d = cfg_v_front;
      v_sync_d  = cfg_v_sync;
      v_back_d  = cfg_v_back;
    end
  end

  always_comb begin
    h_count_d = h_count_q + 12'd1;
    v_count_d = v_count_q;
    if (!enable) begin
      h_count_d = '0;
      v_count_d = '0;
    end else if (h_wrap) begin
      h_count_d = '0;
      v_count_d = v_wrap ? 11'd0 : v_count_q + 11'd1;
    end
  end

  always_comb begin
    hsync_d       = ~SYNC_ACTIVE;
    vsync_d       = ~SYNC_ACTIVE;
    active_d      = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    if (enable) begin
      hsync_d       = h_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_d       = v_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      active_d      = h_in_vis && v_in_vis;
      line_start_d  = (h_count_q == 12'd0);
      frame_start_d = (h_count_q == 12'd0) && (v_count_q == 11'd0);
      if (h_in_vis && v_in_vis) begin
        pixel_x_d = h_count_q[10:0];
        pixel_y_d = v_count_q[9:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_vis_q       <= 11'(H_VISIBLE);
      h_front_q     <= 11'(H_FRONT);
      h_sync_q      <= 11'(H_SYNC);
      h_back_q      <= 11'(H_BACK);
      v_vis_q       <= 10'(V_VISIBLE);
      v_front_q     <= 10'(V_FRONT);
      v_sync_q      <= 10'(V_SYNC);
      v_back_q      <= 10'(V_BACK);
      h_count_q     <= '0;
      v_count_q     <= '0;
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
    end else begin
      h_vis_q       <= h_vis_d;
      h_front_q     <= h_front_d;
      h_sync_q      <= h_sync_d;
      h_back_q      <= h_back_d;
      v_vis_q       <= v_vis_d;
      v_front_q     <= v_front_d;
      v_sync_q      <= v_sync_d;
      v_back_q      <= v_back_d;
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
    end
  end

  // Fetch runs one cycle ahead of the registered stage to cover the framebuffer read
  assign fetch_valid = enable && !rst && h_in_vis && v_in_vis;
  assign fetch_x     = h_count_q[10:0];
  assign fetch_y     = v_count_q[9:0];

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: a cycle-index raster model checked every cycle, plus
// directed measurements of pulse widths, periods and strobes against hand-computed values.
module tb_vga_timing_generator;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic [10:0] cfg_h_visible, cfg_h_front, cfg_h_sync, cfg_h_back;
  logic [9:0]  cfg_v_visible, cfg_v_front, cfg_v_sync, cfg_v_back;
  logic        fetch_valid, hsync, vsync, active, line_start, frame_start;
  logic [10:0] fetch_x, pixel_x;
  logic [9:0]  fetch_y, pixel_y;

  always #5 clk = ~clk;

  vga_timing_generator dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cfg_h_visible(cfg_h_visible), .cfg_h_front(cfg_h_front),
    .cfg_h_sync(cfg_h_sync), .cfg_h_back(cfg_h_back),
    .cfg_v_visible(cfg_v_visible), .cfg_v_front(cfg_v_front),
    .cfg_v_sync(cfg_v_sync), .cfg_v_back(cfg_v_back),
    .fetch_valid(fetch_valid), .fetch_x(fetch_x), .fetch_y(fetch_y),
    .hsync(hsync), .vsync(vsync), .active(active),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .line_start(line_start), .frame_start(frame_start)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: position is a linear cycle index within the frame; h/v derived by div/mod.
  bit m_ok = 1'b0, e_valid = 1'b0;
  int m_t;
  int s_hv, s_hf, s_hs, s_hb, s_vv, s_vf, s_vs, s_vb;
  int e_hs, e_vs, e_act, e_ls, e_fs, e_px, e_py;
  int m_htot, m_vtot, m_h, m_v, m_fv;

  task automatic load_shadow_from_ports();
    s_hv = cfg_h_visible; s_hf = cfg_h_front; s_hs = cfg_h_sync; s_hb = cfg_h_back;
    s_vv = cfg_v_visible; s_vf = cfg_v_front; s_vs = cfg_v_sync; s_vb = cfg_v_back;
  endtask

  always @(negedge clk) begin
    m_htot = s_hv + s_hf + s_hs + s_hb;
    m_vtot = s_vv + s_vf + s_vs + s_vb;
    m_h = (m_htot > 0) ? m_t % m_htot : 0;
    m_v = (m_htot > 0) ? m_t / m_htot : 0;
    if (e_valid) begin
      check("hsync", hsync, e_hs);
      check("vsync", vsync, e_vs);
      check("active", active, e_act);
      check("line_start", line_start, e_ls);
      check("frame_start", frame_start, e_fs);
      check("pixel_x", pixel_x, e_px);
      check("pixel_y", pixel_y, e_py);
    end
    if (m_ok) begin
      m_fv = (!rst && enable && m_h < s_hv && m_v < s_vv) ? 1 : 0;
      check("fetch_valid", fetch_valid, m_fv);
      if (m_fv == 1) begin
        check("fetch_x", fetch_x, m_h);
        check("fetch_y", fetch_y, m_v);
      end
    end
    if (rst) begin
      m_ok = 1'b1; e_valid = 1'b1; m_t = 0;
      s_hv = 100; s_hf = 5; s_hs = 16; s_hb = 11;
      s_vv = 600; s_vf = 1; s_vs = 4; s_vb = 23;
      e_hs = 1; e_vs = 1; e_act = 0; e_ls = 0; e_fs = 0; e_px = 0; e_py = 0;
    end else if (m_ok) begin
      if (!enable) begin
        m_t = 0;
        load_shadow_from_ports();
        e_hs = 1; e_vs = 1; e_act = 0; e_ls = 0; e_fs = 0;
      end else begin
        e_act = (m_h < s_hv && m_v < s_vv) ? 1 : 0;
        if (e_act == 1) begin
          e_px = m_h;
          e_py = m_v;
        end
        e_hs = (m_h >= s_hv + s_hf && m_h < s_hv + s_hf + s_hs) ? 0 : 1;
        e_vs = (m_v >= s_vv + s_vf && m_v < s_vv + s_vf + s_vs) ? 0 : 1;
        e_ls = (m_h == 0) ? 1 : 0;
        e_fs = (m_h == 0 && m_v == 0) ? 1 : 0;
        m_t++;
        if (m_t == m_htot * m_vtot) begin
          m_t = 0;
          load_shadow_from_ports();
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int hv, hf, hs, hb, vv, vf, vs, vb);
    cfg_h_visible = 11'(hv); cfg_h_front = 11'(hf); cfg_h_sync = 11'(hs); cfg_h_back = 11'(hb);
    cfg_v_visible = 10'(vv); cfg_v_front = 10'(vf); cfg_v_sync = 10'(vs); cfg_v_back = 10'(vb);
  endtask

  // Low width and fall-to-fall period of hsync (vert=0) or vsync (vert=1); -1 on timeout.
  task automatic measure(input bit vert, input int limit, output int low, output int period);
    logic prev, cur;
    int n, c;
    low = -1; period = -1;
    @(negedge clk);
    prev = vert ? vsync : hsync;
    n = 0;
    while (n < limit) begin
      @(negedge clk);
      cur = vert ? vsync : hsync;
      n++;
      if (prev && !cur) break;
      prev = cur;
    end
    if (n >= limit) return;
    prev = 1'b0; c = 0;
    while (n < 2 * limit) begin
      @(negedge clk);
      cur = vert ? vsync : hsync;
      c++; n++;
      if (cur && low < 0) low = c;
      if (prev && !cur) begin
        period = c;
        return;
      end
      prev = cur;
    end
  endtask

  task automatic wait_fs(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (frame_start) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  int lo, per, cnt, guard;
  bit ok;
  int hs_pat[8], act_pat[8], vs_pat[8];

  initial begin
    rst = 1'b1; enable = 1'b1;
    set_cfg(100, 5, 16, 11, 600, 1, 4, 23);
    repeat (3) step();
    check("reset_hsync", hsync, 1);
    check("reset_vsync", vsync, 1);
    check("reset_active", active, 0);
    rst = 1'b0;

    // Default horizontal timing: 16-clock pulse, 132-clock period
    measure(1'b0, 400, lo, per);
    check("def_hsync_low", lo, 16);
    check("def_hsync_period", per, 132);

    // Shorter frame (10/1/4/3 lines) loaded by a short disable
    set_cfg(100, 5, 16, 11, 10, 1, 4, 3);
    step(); enable = 1'b0;
    step(); step(); enable = 1'b1;
    @(negedge clk);
    check("reen_fetch_valid", fetch_valid, 1);
    check("reen_fetch_x", fetch_x, 0);
    @(negedge clk);
    check("reen_frame_start", frame_start, 1);
    check("first_active", active, 1);
    check("first_pixel_x", pixel_x, 0);
    check("first_pixel_y", pixel_y, 0);

    measure(1'b1, 6000, lo, per);
    check("vsync_low", lo, 528);
    check("vsync_period", per, 2376);

    wait_fs(3000, ok);
    check("fs_seen_a", ok, 1);
    cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if (active) cnt++;
      @(negedge clk);
      if (frame_start) break;
    end
    check("active_per_frame", cnt, 1000);

    // Mid-frame hsync change applies only from the next frame
    repeat (660) step();
    cfg_h_sync = 11'd8;
    measure(1'b0, 400, lo, per);
    check("cur_frame_hsync_low", lo, 16);
    check("cur_frame_hsync_period", per, 132);
    wait_fs(3000, ok);
    check("fs_seen_b", ok, 1);
    measure(1'b0, 400, lo, per);
    check("next_frame_hsync_low", lo, 8);
    check("next_frame_hsync_period", per, 124);
    step();
    cfg_h_sync = 11'd16;

    // Disable mid-line at h=50 for 10 cycles
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(fetch_valid && fetch_x == 11'd49) && guard < 3000);
    check("found_h49", (guard < 3000) ? 1 : 0, 1);
    step();
    enable = 1'b0;
    @(negedge clk);
    check("dis_fetch_valid", fetch_valid, 0);
    @(negedge clk);
    check("dis_hsync", hsync, 1);
    check("dis_active", active, 0);
    repeat (9) step();
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("dis_reen_frame_start", frame_start, 1);

    // Reset during an hsync pulse
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (hsync && guard < 400);
    check("found_hsync_pulse", (guard < 400) ? 1 : 0, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_hsync", hsync, 1);
    check("rst_pixel_x", pixel_x, 0);
    measure(1'b0, 400, lo, per);
    check("rst_hsync_low", lo, 16);
    check("rst_hsync_period", per, 132);
    repeat (2640) step();

    // Minimal 1/0/1/0 raster
    set_cfg(1, 0, 1, 0, 1, 0, 1, 0);
    enable = 1'b0;
    step();
    enable = 1'b1;
    wait_fs(20, ok);
    check("fs_seen_min", ok, 1);
    for (int i = 0; i < 8; i++) begin
      hs_pat[i] = hsync; act_pat[i] = active; vs_pat[i] = vsync;
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      check("min_hsync", hs_pat[i], (i % 2 == 0) ? 1 : 0);
      check("min_active", act_pat[i], (i % 4 == 0) ? 1 : 0);
      check("min_vsync", vs_pat[i], (i % 4 < 2) ? 1 : 0);
    end

    // Zero sync fields and zero visible lines
    step();
    set_cfg(4, 0, 0, 2, 0, 1, 0, 1);
    enable = 1'b0;
    step();
    enable = 1'b1;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!hsync || !vsync || active) cnt++;
    end
    check("zero_fields_quiet", cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
